// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - MAR/MDR memory port bundle between datapath and mem_responder
//
// Signals:
//   mar_addr   : word address from MAR (master -> slave)
//   mdr_data   : write data from MDR (master -> slave)
//   read       : level read request (master -> slave)
//   write      : level write request (master -> slave)
//   m_data_out : read data to datapath m_data_in (slave -> master)
//   mem_busy   : access in progress (slave -> master)
//   mem_ready  : access complete, held until both strobes drop (slave -> master)
//   addr_err   : completed access was illegal, valid with mem_ready (slave -> master)
interface mem_responder_if;
  logic [31:0] mar_addr;
  logic [31:0] mdr_data;
  logic        read;
  logic        write;
  logic [31:0] m_data_out;
  logic        mem_busy;
  logic        mem_ready;
  logic        addr_err;

  modport master (
    output mar_addr, mdr_data, read, write,
    input  m_data_out, mem_busy, mem_ready, addr_err
  );

  modport slave (
    input  mar_addr, mdr_data, read, write,
    output m_data_out, mem_busy, mem_ready, addr_err
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed wait-state memory answering the MAR/MDR port
//
// Ports:
//   clk : single clock, rising edge
//   clr : synchronous active-low reset (memory contents are kept)
//   bus : mem_responder_if.slave - request strobes, address/data in, read data and status out
module mem_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            clr,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ILLEGAL} op_t;

  state_t                  state;
  op_t                     op;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    in_range;
  logic [31:0]             wdata;
  logic [31:0]             dout;
  logic                    busy;
  logic                    ready;
  logic                    err;
  logic [31:0]             mem [DEPTH];
  logic                    mem_we;

  // Range is judged on the full 32-bit address at acceptance, so high
  // addresses never alias onto the array through the truncated index.
  assign mem_we = clr && (state == S_WAIT) && (cnt == 4'd0) &&
                  (op == OP_WRITE) && in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
      dout  <= 32'd0;
      busy  <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.read || bus.write) begin
            idx      <= bus.mar_addr[ADDR_WIDTH-1:0];
            in_range <= (bus.mar_addr < 32'(DEPTH));
            wdata    <= bus.mdr_data;
            if (bus.read && bus.write) op <= OP_ILLEGAL;
            else if (bus.read)         op <= OP_READ;
            else                       op <= OP_WRITE;
            cnt   <= 4'(WAIT_CYCLES);
            busy  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready <= 1'b1;
            state <= S_RESP;
            case (op)
              OP_READ: begin
                if (in_range) begin
                  dout <= mem[idx];
                  err  <= 1'b0;
                end else begin
                  dout <= 32'd0;
                  err  <= 1'b1;
                end
              end
              // Writes never disturb the last read result.
              OP_WRITE: err <= !in_range;
              default: begin
                dout <= 32'd0;
                err  <= 1'b1;
              end
            endcase
          end
        end
        S_RESP: begin
          // Four-phase: wait for both strobes low so a held strobe
          // cannot start a second access.
          if (!bus.read && !bus.write) begin
            state <= S_IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_data_out = dout;
  assign bus.mem_busy   = busy;
  assign bus.mem_ready  = ready;
  assign bus.addr_err   = err;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;
  localparam int W     = 2;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .ADDR_WIDTH(9), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of words plus last read result.
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] edout,
                                output logic eerr);
    if (rd && wr) begin
      last_rd = 32'd0;
      eerr    = 1'b1;
    end else if (rd) begin
      if (addr < DEPTH) begin
        last_rd = mdl[addr];
        eerr    = 1'b0;
      end else begin
        last_rd = 32'd0;
        eerr    = 1'b1;
      end
    end else begin
      if (addr < DEPTH) begin
        mdl[addr] = data;
        eerr      = 1'b0;
      end else begin
        eerr      = 1'b1;
      end
    end
    edout = last_rd;
  endfunction

  // One full handshake. Inputs change on negedges; outputs sampled on negedges.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input logic chg,
                        input logic [31:0] chg_addr, output logic [31:0] dout,
                        output logic err);
    int n;
    bit got;
    bit hold_ok;
    @(negedge clk);
    bus.read     = rd;
    bus.write    = wr;
    bus.mar_addr = addr;
    bus.mdr_data = data;
    n   = 0;
    got = 0;
    while (n < 50 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("busy_rise", 32'(bus.mem_busy), 32'd1);
        if (chg) bus.mar_addr = chg_addr;
      end
      if (bus.mem_ready) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got no mem_ready expected ready within 50 cycles");
    end else begin
      check("latency", 32'(n - 1), 32'(W + 1));
      check("busy_at_ready", 32'(bus.mem_busy), 32'd1);
    end
    dout = bus.m_data_out;
    err  = bus.addr_err;
    if (hold > 0) begin
      hold_ok = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.mem_ready || !bus.mem_busy || bus.m_data_out !== dout) hold_ok = 0;
      end
      check("held_strobe_stable", 32'(hold_ok), 32'd1);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
    check("ready_fall", 32'(bus.mem_ready), 32'd0);
    check("busy_fall", 32'(bus.mem_busy), 32'd0);
    check("err_clear", 32'(bus.addr_err), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int hold, input logic chg, input logic [31:0] chg_addr);
    logic [31:0] edout, gdout;
    logic        eerr, gerr;
    model(rd, wr, addr, data, edout, eerr);
    access(rd, wr, addr, data, hold, chg, chg_addr, gdout, gerr);
    check({nm, "_data"}, gdout, edout);
    check({nm, "_err"}, 32'(gerr), 32'(eerr));
  endtask

  initial begin
    logic [31:0] gdout, edout, a, d;
    logic        gerr, eerr;
    int          r;

    vecs[0]  = '{1'b0, 1'b1, 32'd5,         32'h28918000, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd5,         32'h0,        32'h28918000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd7,         32'hDEADBEEF, 32'h28918000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd7,         32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h00000200,  32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'hFFFFFFFF,  32'h55AA55AA, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'd511,       32'h12345678, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'd511,       32'h0,        32'h12345678, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'd5,         32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'd5,         32'h0,        32'h28918000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h10000005,  32'h0,        32'h0,        1'b1};

    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.mar_addr = 32'd0;
    bus.mdr_data = 32'd0;
    clr          = 1'b0;
    last_rd      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_dout", bus.m_data_out, 32'd0);
    check("rst_busy", 32'(bus.mem_busy), 32'd0);
    check("rst_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_err", 32'(bus.addr_err), 32'd0);
    clr = 1'b1;

    // Table-driven directed vectors; the model is kept in step for later phases.
    foreach (vecs[i]) begin
      model(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, edout, eerr);
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 0, 1'b0, 32'd0, gdout, gerr);
      check($sformatf("vec%0d_data", i), gdout, vecs[i].exp_dout);
      check($sformatf("vec%0d_err", i), 32'(gerr), 32'(vecs[i].exp_err));
    end

    // Fill the whole array, poke an out-of-range write, then read everything back.
    for (int i = 0; i < DEPTH; i++) run_op("fill", 1'b0, 1'b1, 32'(i), $urandom, 0, 1'b0, 32'd0);
    run_op("oor_wr", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'd0);
    for (int i = 0; i < DEPTH; i++) run_op("readback", 1'b1, 1'b0, 32'(i), 32'd0, 0, 1'b0, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 4) == 0) ? (32'd512 + ($urandom & 32'h7FFFFFFF)) : 32'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      if (r < 4)       run_op("rnd_rd", 1'b1, 1'b0, a, d, 0, 1'b0, 32'd0);
      else if (r < 9)  run_op("rnd_wr", 1'b0, 1'b1, a, d, 0, 1'b0, 32'd0);
      else             run_op("rnd_both", 1'b1, 1'b1, a, d, 0, 1'b0, 32'd0);
    end

    // Held read strobe: one access only.
    run_op("held", 1'b1, 1'b0, 32'd5, 32'd0, 20, 1'b0, 32'd0);

    // Address change after acceptance must be ignored.
    run_op("pre7", 1'b0, 1'b1, 32'd7, ~mdl[5], 0, 1'b0, 32'd0);
    run_op("addr_chg", 1'b1, 1'b0, 32'd5, 32'd0, 0, 1'b1, 32'd7);

    // Reset in the middle of a write's wait states.
    run_op("pre3", 1'b0, 1'b1, 32'd3, 32'h1, 0, 1'b0, 32'd0);
    run_op("pre_rd", 1'b1, 1'b0, 32'd7, 32'd0, 0, 1'b0, 32'd0);
    @(negedge clk);
    bus.write    = 1'b1;
    bus.mar_addr = 32'd3;
    bus.mdr_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("mid_busy", 32'(bus.mem_busy), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    check("mid_rst_dout", bus.m_data_out, 32'd0);
    check("mid_rst_busy", 32'(bus.mem_busy), 32'd0);
    check("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
    check("mid_rst_err", 32'(bus.addr_err), 32'd0);
    bus.write = 1'b0;
    clr       = 1'b1;
    last_rd   = 32'd0;
    run_op("post_rst_rd3", 1'b1, 1'b0, 32'd3, 32'd0, 0, 1'b0, 32'd0);
    check("post_rst_val3", mdl[3], 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous memory that answers the datapath's MAR/MDR memory port. It sits on the far side of the `read`/`write` strobes and drives the datapath's `m_data_in` bus, replacing bench-driven memory data. Requests complete after a configurable wait-state latency. Completion uses a four-phase request/ready handshake, so a held strobe never causes a second access.

## Interface
- `DEPTH`, 512: number of 32-bit words.
- `ADDR_WIDTH`, 9: index bits used from `mar_addr`; `2**ADDR_WIDTH` must be at least `DEPTH`.
- `WAIT_CYCLES`, 2: extra wait states per access; 0–15 legal.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `clr` in 1: synchronous, active-low reset.
- `mar_addr` in 32: word address, taken from MAR output.
- `mdr_data` in 32: write data, taken from MDR output.
- `read` in 1: read request, level.
- `write` in 1: write request, level.
- `m_data_out` out 32: read data, wired to datapath `m_data_in`.
- `mem_busy` out 1: access in progress.
- `mem_ready` out 1: access complete, held until strobes drop.
- `addr_err` out 1: completed access was illegal; valid while `mem_ready`=1.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `mem_busy`=0, `mem_ready`=0.
  - On an edge with `read`^`write`=1: latch `mar_addr` and `mdr_data`, latch the op, load `cnt`=`WAIT_CYCLES`, go to WAIT.
  - On an edge with `read`=`write`=1: latch op=ILLEGAL, go to WAIT.
- WAIT: `mem_busy`=1.
  - On an edge with `cnt`≠0: decrement `cnt`.
  - On an edge with `cnt`=0, perform the access and go to RESP:
    - Read, legal: `m_data_out`←`mem[addr]`, `addr_err`←0.
    - Write, legal: `mem[addr]`←latched data, `addr_err`←0; `m_data_out` unchanged.
    - Out of range (`mar_addr` ≥ `DEPTH`, full 32-bit compare) or ILLEGAL: no memory access, `addr_err`←1. `m_data_out`←0 for reads and ILLEGAL; unchanged for writes.
- RESP: `mem_busy`=1, `mem_ready`=1.
  - Stays in RESP while `read` or `write` is high.
  - On the first edge with both low: go to IDLE and clear `addr_err`.
- Address and data are sampled only at acceptance; later changes to `mar_addr`/`mdr_data` are ignored.
- `m_data_out` holds its last read result until the next completed read.
- Reset (`clr`=0 at an edge), in any state:
  - Next state is IDLE.
  - `m_data_out`=0, `mem_busy`=0, `mem_ready`=0, `addr_err`=0, `cnt`=0.
  - A write still in WAIT is discarded, not committed.
  - Memory array contents are not cleared.
- Reset while strobes remain high: a new request is accepted on the first edge after `clr` returns to 1.

## Timing
- Acceptance edge E0 (IDLE, strobe high).
- `mem_busy` rises after E0.
- The access commits and `mem_ready` rises after edge E0+`WAIT_CYCLES`+1.
- `WAIT_CYCLES`=0: ready after E1, a 1-cycle latency.
- `mem_ready` falls after the first edge where `read`=`write`=0; the earliest next acceptance is the following edge.
- Minimum back-to-back period: `WAIT_CYCLES`+3 cycles.
- `m_data_out` is valid in the same cycle `mem_ready` is high; the datapath's MDRin may sample on any edge while `mem_ready`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Write, then read (`WAIT_CYCLES`=2):
  - Write 0x28918000 to addr 5.
  - `mem_ready` rises exactly 3 cycles after acceptance.
  - Drop `write`; `mem_ready` falls 1 cycle later.
  - Read addr 5: `m_data_out`=0x28918000 with `mem_ready`, `addr_err`=0.
- Held strobe:
  - Hold `read` high for 20 cycles at addr 5.
  - Exactly one access; `mem_ready` stays 1 and `mem_busy` stays 1 until `read` drops; no second acceptance.
- Address change after acceptance:
  - Read addr 5; one cycle after acceptance, change `mar_addr` to 7.
  - Data returned is `mem[5]`.
- Out of range:
  - Read `mar_addr`=0x00000200: `addr_err`=1 and `m_data_out`=0 at ready.
  - Write to 0xFFFFFFFF: `addr_err`=1 and no array location modified; verify by readback of addrs 0–511.
- Both strobes:
  - `read`=`write`=1: completes after `WAIT_CYCLES`+1 with `addr_err`=1 and `m_data_out`=0; memory unchanged.
- Reset mid-WAIT:
  - Write 0xFFFFFFFF to addr 3 (prior content 0x1); assert `clr`=0 one cycle after acceptance.
  - All outputs 0.
  - A subsequent read of addr 3 returns 0x1.
